// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        request, sampled only while idle (busy=0)
//   dividend     unsigned dividend, captured on accept
//   divisor      unsigned divisor, captured on accept
//   busy         high while a division is in progress
//   done         one-cycle pulse; quotient/remainder/div_by_zero valid from this cycle
//   quotient     unsigned quotient, held until the next done
//   remainder    unsigned remainder, held until the next done
//   div_by_zero  set with done when the captured divisor was 0, cleared on the next accept
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    // After every step the partial remainder is below the divisor, so its top
    // bit is always zero and only the low WIDTH bits are kept.
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   r_sh, trial;
    // Trial subtraction as complement-and-add; trial[WIDTH]=1 signals a borrow.
    assign r_sh  = {r_q, dq_q[WIDTH-1]};
    assign trial = r_sh + ~{1'b0, dv_q} + {{WIDTH{1'b0}}, 1'b1};
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        dv_d    = dv_q;
        r_d     = r_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                dq_d    = dividend;
                dv_d    = divisor;
                r_d     = '0;
                cnt_d   = '0;
                dbz_d   = 1'b0;
                state_d = RUN;
            end
        end else if (dv_q == '0) begin
            quo_d   = '1;
            rem_d   = dq_q;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
        end else begin
            r_d   = trial[WIDTH] ? r_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            dq_d  = {dq_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                quo_d   = dq_d;
                rem_d   = r_d;
                done_d  = 1'b1;
                state_d = IDLE;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dq_q    <= '0;
            dv_q    <= '0;
            r_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dq_q    <= dq_d;
            dv_q    <= dv_d;
            r_q     <= r_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end
    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard-based bench for seq_restoring_divider.
module tb_seq_restoring_divider;
    localparam int W = 4;
    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    exp_t         sb[$];
    int           checks = 0;
    int           errors = 0;
    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );
    always #5 clk = ~clk;
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.q = (b == 0) ? {W{1'b1}} : W'(a / b);
        e.r = (b == 0) ? a : W'(a % b);
        e.z = (b == 0);
        return e;
    endfunction
    task automatic wait_done(input string name, input int lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
        end else begin
            if (n != lat) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, required %0d", name, n, lat);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s scoreboard: done with empty queue", name);
            end else begin
                e = sb.pop_front();
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.z || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s result: q=%0d r=%0d z=%b busy=%b, required q=%0d r=%0d z=%b busy=0",
                             name, quotient, remainder, div_by_zero, busy, e.q, e.r, e.z);
                end
            end
        end
    endtask
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
        @(negedge clk);
        start = 1'b1;
        dividend = a;
        divisor = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b dbz=%b, required busy=1 dbz=0", name, busy, div_by_zero);
        end
        wait_done(name, (b == 0) ? 1 : W);
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b one cycle later, required 0", name, done);
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
    endtask
    task automatic test_basic;
        do_div(13, 3, "div_13_3");
        do_div(15, 1, "div_15_1");
        do_div(5, 7, "div_5_7");
        do_div(15, 15, "div_15_15");
    endtask
    task automatic test_div_by_zero;
        do_div(9, 0, "div_9_0");
        do_div(8, 2, "div_8_2_after_zero");
    endtask
    task automatic test_sweep;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                do_div(W'(a), W'(b), $sformatf("sweep_%0d_%0d", a, b));
    endtask
    task automatic test_start_while_busy;
        @(negedge clk);
        start = 1'b1;
        dividend = 13;
        divisor = 3;
        sb.push_back(model(13, 3));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        dividend = 6;
        divisor = 2;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start", W - 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_start_extra: done=%b busy=%b at cycle %0d, required 0/0", done, busy, i);
            end
        end
    endtask
    task automatic test_reset_mid_op;
        @(negedge clk);
        start = 1'b1;
        dividend = 13;
        divisor = 3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== '0 || remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b q=%0d r=%0d z=%b, required all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_after: done=%b busy=%b at cycle %0d, required 0/0", done, busy, i);
            end
        end
    endtask
    task automatic test_back_to_back;
        @(negedge clk);
        start = 1'b1;
        dividend = 13;
        divisor = 3;
        sb.push_back(model(13, 3));
        wait_done("b2b_first", W + 1);
        dividend = 14;
        divisor = 4;
        sb.push_back(model(14, 4));
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b, required busy=1 done=0", busy, done);
        end
        wait_done("b2b_second", W);
        @(negedge clk);
        checks++;
        if (sb.size() != 0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: queue=%0d done=%b, required 0/0", sb.size(), done);
        end
    endtask
    initial begin
        test_reset;
        test_basic;
        test_div_by_zero;
        test_start_while_busy;
        test_reset_mid_op;
        test_back_to_back;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
